// File: rtl/pio_in_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface pio_in_debounce_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_debounce_irq.sv
// Debounced input PIO: 2-flop synchroniser, per-bit debounce, edge capture (W1C),
// per-bit IRQ mask and level interrupt, behind an Avalon-MM register map.
module pio_in_debounce_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_in_debounce_irq_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [CntW-1:0]  cnt [WIDTH];
  logic [WIDTH-1:0] edge_capture, irq_mask;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en, mask_we;
  logic [31:0]      rd_word;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH have no destination.
  assign unused_wdata = ^bus.writedata;

  // Two-stage synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // Per-bit debounce: stable follows s2 only after DEBOUNCE_CYCLES consecutive differing clocks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CntLast) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CntW'(1);
        end
      end
    end
  end

  // Edge selection and bus decode.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      32'd0:   edge_hit = stable & ~stable_d;
      32'd1:   edge_hit = ~stable & stable_d;
      default: edge_hit = stable ^ stable_d;
    endcase
    wr_en   = bus.chipselect && !bus.write_n;
    mask_we = wr_en && (bus.address == 2'd1);
    cap_clr = (wr_en && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;
    rd_word = '0;
    case (bus.address)
      2'd0:    rd_word[WIDTH-1:0] = stable;
      2'd1:    rd_word[WIDTH-1:0] = irq_mask;
      2'd3:    rd_word[WIDTH-1:0] = edge_capture;
      default: rd_word = '0;
    endcase
  end

  // Edge-capture and mask registers; a new edge beats a same-cycle W1C clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~cap_clr) | edge_hit;
      if (mask_we) irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  // Read data is registered every clock regardless of chipselect.
  always_ff @(posedge clk) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_word;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Directed bench for pio_in_debounce_irq: a rising-edge 4-bit instance and an
// any-edge 8-bit instance share clock and reset.
module tb_pio_in_debounce_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in0;
  logic [7:0]  in1;
  logic        irq0, irq1;
  logic [31:0] d;
  int          checks = 0;
  int          failures = 0;

  pio_in_debounce_irq_if bus0 ();
  pio_in_debounce_irq_if bus1 ();

  pio_in_debounce_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0),
    .in_port (in0),
    .irq     (irq0)
  );

  pio_in_debounce_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1),
    .in_port (in1),
    .irq     (irq1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input logic [1:0] a, output logic [31:0] q);
    bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
    tick();
    q = bus0.readdata;
    bus0.chipselect = 1'b0;
  endtask

  task automatic wr0(input logic [1:0] a, input logic [31:0] v);
    bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b0; bus0.writedata = v;
    tick();
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
  endtask

  task automatic rd1(input logic [1:0] a, output logic [31:0] q);
    bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b1;
    tick();
    q = bus1.readdata;
    bus1.chipselect = 1'b0;
  endtask

  task automatic wr1(input logic [1:0] a, input logic [31:0] v);
    bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.writedata = v;
    tick();
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] q;
    reset_n = 1'b0; in0 = 4'h0; in1 = 8'h00;
    bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    bus1.address = 2'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    repeat (3) tick();
    checks++;
    if (bus0.readdata !== 32'h0) begin
      failures++; $display("FAIL reset_readdata0: got %h expected %h", bus0.readdata, 32'h0);
    end
    checks++;
    if (irq0 !== 1'b0) begin
      failures++; $display("FAIL reset_irq0: got %b expected 0", irq0);
    end
    checks++;
    if (bus1.readdata !== 32'h0) begin
      failures++; $display("FAIL reset_readdata1: got %h expected %h", bus1.readdata, 32'h0);
    end
    reset_n = 1'b1;
    rd0(2'd0, q);
    checks++;
    if (q !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", q); end
    rd0(2'd1, q);
    checks++;
    if (q !== 32'h0) begin failures++; $display("FAIL reset_mask: got %h expected 0", q); end
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h0) begin failures++; $display("FAIL reset_capture: got %h expected 0", q); end
  endtask

  task automatic test_debounce();
    bus0.address = 2'd0;
    // Held rise on bit 0: stable at edge 6, visible on readdata after edge 7.
    in0 = 4'h1;
    repeat (6) tick();
    checks++;
    if (bus0.readdata !== 32'h0) begin
      failures++; $display("FAIL deb_early: got %h expected %h", bus0.readdata, 32'h0);
    end
    tick();
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++; $display("FAIL deb_rise: got %h expected %h", bus0.readdata, 32'h1);
    end
    // Three-clock pulse on bit 1 must be filtered.
    in0 = 4'h3;
    repeat (3) begin
      tick();
      checks++;
      if (bus0.readdata !== 32'h1) begin
        failures++; $display("FAIL deb_pulse: got %h expected %h", bus0.readdata, 32'h1);
      end
    end
    in0 = 4'h1;
    repeat (8) begin
      tick();
      checks++;
      if (bus0.readdata !== 32'h1) begin
        failures++; $display("FAIL deb_pulse_after: got %h expected %h", bus0.readdata, 32'h1);
      end
    end
    // Bounce 1,0,1,1,... on bit 3: count restarts, stable at edge 8, visible after edge 9.
    in0 = 4'h9; tick();
    in0 = 4'h1; tick();
    in0 = 4'h9;
    repeat (5) tick();
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++; $display("FAIL deb_bounce_7: got %h expected %h", bus0.readdata, 32'h1);
    end
    tick();
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++; $display("FAIL deb_bounce_8: got %h expected %h", bus0.readdata, 32'h1);
    end
    tick();
    checks++;
    if (bus0.readdata !== 32'h9) begin
      failures++; $display("FAIL deb_bounce_9: got %h expected %h", bus0.readdata, 32'h9);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] q;
    wr0(2'd3, 32'hF);
    wr0(2'd1, 32'h5);
    checks++;
    if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_cleared: got %b expected 0", irq0); end
    in0 = 4'hD;
    repeat (6) tick();
    checks++;
    if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_before_edge: got %b expected 0", irq0); end
    tick();
    checks++;
    if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_bit2: got %b expected 1", irq0); end
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h4) begin failures++; $display("FAIL cap_bit2: got %h expected %h", q, 32'h4); end
    in0 = 4'hF;
    repeat (7) tick();
    checks++;
    if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_bit1: got %b expected 1", irq0); end
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h6) begin failures++; $display("FAIL cap_bit21: got %h expected %h", q, 32'h6); end
    wr0(2'd3, 32'h4);
    checks++;
    if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_after_w1c: got %b expected 0", irq0); end
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h2) begin failures++; $display("FAIL cap_after_w1c: got %h expected %h", q, 32'h2); end
    rd0(2'd1, q);
    checks++;
    if (q !== 32'h5) begin failures++; $display("FAIL mask_read: got %h expected %h", q, 32'h5); end
  endtask

  task automatic test_set_wins();
    logic [31:0] q;
    // Falling edge on bit 0 is not captured in rising mode.
    in0 = 4'hE;
    repeat (8) tick();
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h2) begin failures++; $display("FAIL fall_ignored: got %h expected %h", q, 32'h2); end
    wr0(2'd3, 32'hF);
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h0) begin failures++; $display("FAIL cap_clear_all: got %h expected 0", q); end
    // Rise: stable at edge 6, capture sets at edge 7, where the W1C also lands.
    in0 = 4'hF;
    repeat (6) tick();
    wr0(2'd3, 32'h1);
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h1) begin failures++; $display("FAIL set_wins: got %h expected %h", q, 32'h1); end
    checks++;
    if (irq0 !== 1'b1) begin failures++; $display("FAIL set_wins_irq: got %b expected 1", irq0); end
    wr0(2'd3, 32'h1);
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h0) begin failures++; $display("FAIL w1c_plain: got %h expected 0", q); end
    checks++;
    if (irq0 !== 1'b0) begin failures++; $display("FAIL w1c_plain_irq: got %b expected 0", irq0); end
  endtask

  task automatic test_any_edge();
    logic [31:0] q;
    in1 = 8'h80;
    repeat (7) tick();
    rd1(2'd3, q);
    checks++;
    if (q !== 32'h80) begin failures++; $display("FAIL any_rise: got %h expected %h", q, 32'h80); end
    wr1(2'd3, 32'h80);
    rd1(2'd3, q);
    checks++;
    if (q !== 32'h0) begin failures++; $display("FAIL any_clr1: got %h expected 0", q); end
    in1 = 8'h00;
    repeat (7) tick();
    rd1(2'd3, q);
    checks++;
    if (q !== 32'h80) begin failures++; $display("FAIL any_fall: got %h expected %h", q, 32'h80); end
    wr1(2'd3, 32'h80);
    in1 = 8'h80;
    repeat (7) tick();
    rd1(2'd3, q);
    checks++;
    if (q !== 32'h80) begin failures++; $display("FAIL any_rise2: got %h expected %h", q, 32'h80); end
    wr1(2'd2, 32'hFFFF_FFFF);
    rd1(2'd2, q);
    checks++;
    if (q !== 32'h0) begin failures++; $display("FAIL reserved: got %h expected 0", q); end
    wr1(2'd1, 32'hFFFF_FFFF);
    rd1(2'd1, q);
    checks++;
    if (q !== 32'hFF) begin failures++; $display("FAIL mask_upper: got %h expected %h", q, 32'hFF); end
    checks++;
    if (irq1 !== 1'b1) begin failures++; $display("FAIL any_irq: got %b expected 1", irq1); end
    wr1(2'd0, 32'h0);
    rd1(2'd0, q);
    checks++;
    if (q !== 32'h80) begin failures++; $display("FAIL data_ro: got %h expected %h", q, 32'h80); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    reset_n = 1'b0; in0 = 4'h0;
    repeat (2) tick();
    reset_n = 1'b1;
    bus0.address = 2'd0;
    in0 = 4'h1;
    repeat (4) tick();
    // Counter is at 2 here; reset throws it away.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (bus0.readdata !== 32'h0) begin
      failures++; $display("FAIL mid_reset_early: got %h expected 0", bus0.readdata);
    end
    tick();
    checks++;
    if (bus0.readdata !== 32'h1) begin
      failures++; $display("FAIL mid_reset_rise: got %h expected %h", bus0.readdata, 32'h1);
    end
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h1) begin failures++; $display("FAIL powerup_cap: got %h expected %h", q, 32'h1); end
    repeat (10) tick();
    rd0(2'd3, q);
    checks++;
    if (q !== 32'h1) begin failures++; $display("FAIL powerup_once: got %h expected %h", q, 32'h1); end
    checks++;
    if (irq0 !== 1'b0) begin failures++; $display("FAIL mask_reset_irq: got %b expected 0", irq0); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_edge_irq();
    test_set_wins();
    test_any_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
